// File: rtl/axi_lite_cmd_master_if.sv
// AXI-Lite bus bundle between a command master and a register slave.
interface axi_lite_cmd_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master: turns one command into one AXI-Lite
// read or write and hands back the response; sticky watchdog for hung slaves.
module axi_lite_cmd_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_rnw,
  output logic [1:0]                  resp_code,
  output logic [AXI_DATA_WIDTH-1:0]   resp_rdata,
  output logic                        timeout_err,
  axi_lite_cmd_master_if.master       axi_lite_m
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t state, next_state;

  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q, resp_valid_q;
  logic aw_valid_d, w_valid_d, ar_valid_d, b_ready_d, r_ready_d, resp_valid_d;
  logic aw_done, w_done;
  logic [1:0]                  resp_code_q;
  logic [AXI_DATA_WIDTH-1:0]   resp_rdata_q;
  logic                        resp_rnw_q;
  logic [CNT_W-1:0]            wd_cnt;
  logic                        timeout_q;

  logic cmd_fire, aw_hs, w_hs, ar_hs, busy;

  assign cmd_fire = (state == IDLE) && cmd_valid;
  assign aw_hs    = aw_valid_q && axi_lite_m.awready;
  assign w_hs     = w_valid_q && axi_lite_m.wready;
  assign ar_hs    = ar_valid_q && axi_lite_m.arready;
  assign busy     = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (cmd_fire) next_state = cmd_rnw ? RD_REQ : WR_REQ;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = WR_RESP;
      WR_RESP: if (axi_lite_m.bvalid) next_state = DONE;
      RD_REQ:  if (ar_hs) next_state = RD_RESP;
      RD_RESP: if (axi_lite_m.rvalid) next_state = DONE;
      DONE:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered handshake outputs; AW and W drop independently.
  always_comb begin
    cmd_ready    = (state == IDLE);
    aw_valid_d   = 1'b0;
    w_valid_d    = 1'b0;
    ar_valid_d   = 1'b0;
    b_ready_d    = (next_state == WR_RESP);
    r_ready_d    = (next_state == RD_RESP);
    resp_valid_d = (next_state == DONE);
    unique case (state)
      IDLE: begin
        aw_valid_d = cmd_fire && !cmd_rnw;
        w_valid_d  = cmd_fire && !cmd_rnw;
        ar_valid_d = cmd_fire && cmd_rnw;
      end
      WR_REQ: begin
        aw_valid_d = aw_valid_q && !axi_lite_m.awready;
        w_valid_d  = w_valid_q && !axi_lite_m.wready;
      end
      RD_REQ:  ar_valid_d = ar_valid_q && !axi_lite_m.arready;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      b_ready_q    <= 1'b0;
      r_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      resp_code_q  <= '0;
      resp_rdata_q <= '0;
      resp_rnw_q   <= 1'b0;
      wd_cnt       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      ar_valid_q   <= ar_valid_d;
      b_ready_q    <= b_ready_d;
      r_ready_q    <= r_ready_d;
      resp_valid_q <= resp_valid_d;

      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if ((state == WR_RESP) && axi_lite_m.bvalid) begin
        resp_code_q  <= axi_lite_m.bresp;
        resp_rdata_q <= '0;
        resp_rnw_q   <= 1'b0;
      end
      if ((state == RD_RESP) && axi_lite_m.rvalid) begin
        resp_code_q  <= axi_lite_m.rresp;
        resp_rdata_q <= axi_lite_m.rdata;
        resp_rnw_q   <= 1'b1;
      end

      // Flag is raised on the same edge the counter reaches the limit.
      if (cmd_fire)
        wd_cnt <= '0;
      else if (busy && (wd_cnt != CNT_MAX))
        wd_cnt <= wd_cnt + CNT_W'(1);
      if ((TIMEOUT_CYCLES != 0) && busy && (wd_cnt == CNT_LAST))
        timeout_q <= 1'b1;
    end
  end

  assign axi_lite_m.awaddr  = addr_q;
  assign axi_lite_m.araddr  = addr_q;
  assign axi_lite_m.wdata   = wdata_q;
  assign axi_lite_m.wstrb   = wstrb_q;
  assign axi_lite_m.awvalid = aw_valid_q;
  assign axi_lite_m.wvalid  = w_valid_q;
  assign axi_lite_m.arvalid = ar_valid_q;
  assign axi_lite_m.bready  = b_ready_q;
  assign axi_lite_m.rready  = r_ready_q;

  assign resp_valid  = resp_valid_q;
  assign resp_code   = resp_code_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_rnw    = resp_rnw_q;
  assign timeout_err = timeout_q;

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI-Lite master that converts a simple command/response handshake into AXI-Lite write or read transactions. It is the initiating end of the AXI-Lite slave interfaces used across the design, e.g. for register access, config sequencers, and exercising error-responding slaves. It handles independent AW/W acceptance order, returns BRESP/RRESP and RDATA to the requester, and provides a sticky watchdog flag for hung slaves.

## Interface
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width (32 or 64)
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog
- aclk  in  1  clock; all logic is synchronous to it
- areset  in  1  reset, asynchronous and active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_addr  in  AXI_ADDR_WIDTH  target address
- cmd_wdata  in  AXI_DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  AXI_DATA_WIDTH/8  write strobes (ignored for reads)
- resp_valid / resp_ready  out/in  1  response handshake
- resp_rnw  out  1  echo of cmd_rnw
- resp_code  out  2  BRESP or RRESP
- resp_rdata  out  AXI_DATA_WIDTH  RDATA; 0 for writes
- timeout_err  out  1  sticky watchdog flag
- axi_lite_m_aw*, w*, b*, ar*, r*  standard AXI-Lite master ports, mirroring the slave port set (awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready)

## Operation
- Every output is registered. The exception is cmd_ready, which is decoded from the state.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On a cmd handshake, latch addr, wdata, wstrb and rnw.
  - Go to RD_REQ if rnw = 1, otherwise WR_REQ.
  - Assert arvalid, or both awvalid and wvalid, on the next edge.
- WR_REQ:
  - awvalid stays high until the AW handshake, then drops.
  - wvalid stays high until the W handshake, then drops independently of awvalid.
  - Flags aw_done and w_done record each handshake.
  - When both are complete (including both completing in the same cycle), go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, latch bresp into resp_code, set resp_rdata = 0, go to DONE.
- RD_REQ: arvalid stays high until the AR handshake, then go to RD_RESP.
- RD_RESP: rready = 1. On rvalid, latch rresp and rdata, go to DONE.
- DONE: resp_valid = 1 until resp_ready, then go to IDLE.
- Only one transaction is ever outstanding. A new command is not accepted before the response handshake completes.
- Address, data and strobe outputs hold their latched value while the matching valid is high.
- Watchdog:
  - Counter of width $clog2(TIMEOUT_CYCLES+1).
  - Cleared on a cmd handshake; increments in WR_REQ, WR_RESP, RD_REQ and RD_RESP; saturates.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set.
  - timeout_err is cleared only by reset. The transaction is not abandoned.

## Timing
- Reset values:
  - state = IDLE.
  - All AXI valid/ready outputs = 0.
  - resp_valid = 0, timeout_err = 0.
  - resp_code = 0, resp_rdata = 0, resp_rnw = 0.
  - Latched address, data and strobe = 0.
  - Watchdog counter = 0.
  - cmd_ready is 1 from the first edge after reset deasserts.
- Reset mid-transaction drops every valid output immediately (asynchronous). No response is produced for the aborted command.
- Minimum write, with slave readies always high:
  - Cycle 0: cmd handshake.
  - Cycle 1: awvalid = wvalid = 1, both accepted.
  - Cycle 2: bready = 1, bvalid accepted.
  - Cycle 3: resp_valid = 1, resp_ready = 1.
  - Cycle 4: cmd_ready = 1.
- Minimum read has the same 4-cycle structure: ar, r, resp.
- bready and rready are never high outside WR_RESP and RD_RESP respectively.
- No valid output drops before its handshake completes.

## Test plan
- Write 0xDEADBEEF, wstrb 0xF, to 0x10 with slave readies always high:
  - awvalid and wvalid are high in cycle 1; bready is high in cycle 2; resp_valid is high in cycle 3.
  - resp_code = 2'b00, resp_rnw = 0, resp_rdata = 0.
- wready high at cycle 1, awready delayed to cycle 4:
  - wvalid is low from cycle 2; awvalid is high during cycles 1–4.
  - bready is not high until cycle 5.
  - The response matches bresp.
- Read from 0x20 against an always-SLVERR slave (rdata = 0, rresp = 2'b10):
  - resp_rnw = 1, resp_code = 2'b10, resp_rdata = 0.
  - cmd_ready is low from acceptance until the cycle after the resp handshake.
- Read returning rdata 0x12345678 with resp_ready held low for 5 cycles:
  - resp_valid and resp_rdata hold steady for all 5 cycles.
  - The second cmd_valid, asserted throughout, is not accepted until IDLE.
- TIMEOUT_CYCLES = 8, awready held low:
  - timeout_err rises 8 cycles after the cmd handshake and awvalid remains high.
  - Releasing awready completes the write normally; timeout_err stays 1.
- Assert areset while in WR_RESP:
  - All valid and ready outputs are 0 within the same cycle.
  - After deassertion, a fresh read completes correctly.
